// File: rtl/axi_stream_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi_stream_rr_arbiter
// Purpose  : Packet-level round-robin merge of NUM_PORTS 512-bit AXI4-Stream
//            slaves onto one registered master port, with per-port counters.
// Revision : 1.0 - initial release
// ============================================================================
module axi_stream_rr_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int CNT_W     = 32
) (
    input  logic                       axis_aclk,
    input  logic                       axis_rst,
    input  logic [NUM_PORTS-1:0]       s_axis_tvalid,
    input  logic [512*NUM_PORTS-1:0]   s_axis_tdata,
    input  logic [64*NUM_PORTS-1:0]    s_axis_tkeep,
    input  logic [NUM_PORTS-1:0]       s_axis_tlast,
    input  logic [16*NUM_PORTS-1:0]    s_axis_tuser_size,
    input  logic [16*NUM_PORTS-1:0]    s_axis_tuser_src,
    input  logic [16*NUM_PORTS-1:0]    s_axis_tuser_dst,
    output logic [NUM_PORTS-1:0]       s_axis_tready,
    output logic                       m_axis_tvalid,
    output logic [511:0]               m_axis_tdata,
    output logic [63:0]                m_axis_tkeep,
    output logic                       m_axis_tlast,
    output logic [15:0]                m_axis_tuser_size,
    output logic [15:0]                m_axis_tuser_src,
    output logic [15:0]                m_axis_tuser_dst,
    input  logic                       m_axis_tready,
    output logic [3:0]                 grant_idx,
    output logic                       busy,
    output logic [CNT_W*NUM_PORTS-1:0] pkt_count
);

    localparam int         c_IDX_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_PKT  = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [c_IDX_W-1:0] r_grant;
    logic [c_IDX_W-1:0] r_last_grant;
    logic [c_IDX_W-1:0] w_pick;
    logic [c_IDX_W-1:0] w_pick_hi;
    logic [c_IDX_W-1:0] w_pick_lo;
    logic               w_found_hi;
    logic               w_any_req;
    logic               w_out_ready;
    logic               w_accept;

    logic               w_sel_valid;
    logic               w_sel_last;
    logic [511:0]       w_sel_data;
    logic [63:0]        w_sel_keep;
    logic [15:0]        w_sel_size;
    logic [15:0]        w_sel_src;
    logic [15:0]        w_sel_dst;

    logic               r_m_tvalid;
    logic [511:0]       r_m_tdata;
    logic [63:0]        r_m_tkeep;
    logic               r_m_tlast;
    logic [15:0]        r_m_tsize;
    logic [15:0]        r_m_tsrc;
    logic [15:0]        r_m_tdst;
    logic [CNT_W-1:0]   r_pkt_count [NUM_PORTS];

    assign w_any_req   = |s_axis_tvalid;
    assign w_out_ready = ~r_m_tvalid | m_axis_tready;
    assign w_accept    = (r_state == c_ST_PKT) & w_sel_valid & w_out_ready;

    // Rotating priority: lowest requester above last_grant wins, otherwise
    // wrap to the lowest requester at or below it.
    always_comb begin
        w_pick_hi  = '0;
        w_pick_lo  = '0;
        w_found_hi = 1'b0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (s_axis_tvalid[i]) begin
                if (i > int'(r_last_grant)) begin
                    w_found_hi = 1'b1;
                    w_pick_hi  = c_IDX_W'(i);
                end else begin
                    w_pick_lo  = c_IDX_W'(i);
                end
            end
        end
        w_pick = w_found_hi ? w_pick_hi : w_pick_lo;
    end

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_data  = '0;
        w_sel_keep  = '0;
        w_sel_size  = '0;
        w_sel_src   = '0;
        w_sel_dst   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (r_grant == c_IDX_W'(i)) begin
                w_sel_valid = s_axis_tvalid[i];
                w_sel_last  = s_axis_tlast[i];
                w_sel_data  = s_axis_tdata[512*i +: 512];
                w_sel_keep  = s_axis_tkeep[64*i +: 64];
                w_sel_size  = s_axis_tuser_size[16*i +: 16];
                w_sel_src   = s_axis_tuser_src[16*i +: 16];
                w_sel_dst   = s_axis_tuser_dst[16*i +: 16];
            end
        end
    end

    // Ready depends only on registered state and downstream ready.
    always_comb begin
        s_axis_tready = '0;
        if (r_state == c_ST_PKT) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (r_grant == c_IDX_W'(i)) begin
                    s_axis_tready[i] = w_out_ready;
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (w_any_req) w_state_nxt = c_ST_PKT;
            c_ST_PKT:  if (w_accept && w_sel_last) w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge axis_aclk or posedge axis_rst) begin
        if (axis_rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge axis_aclk or posedge axis_rst) begin
        if (axis_rst) begin
            r_grant      <= '0;
            r_last_grant <= c_IDX_W'(NUM_PORTS - 1);
        end else if ((r_state == c_ST_IDLE) && w_any_req) begin
            r_grant      <= w_pick;
            r_last_grant <= w_pick;
        end
    end

    // Output slice: fields load only on accept and hold while stalled.
    always_ff @(posedge axis_aclk or posedge axis_rst) begin
        if (axis_rst) begin
            r_m_tvalid <= 1'b0;
            r_m_tdata  <= '0;
            r_m_tkeep  <= '0;
            r_m_tlast  <= 1'b0;
            r_m_tsize  <= '0;
            r_m_tsrc   <= '0;
            r_m_tdst   <= '0;
        end else if (w_accept) begin
            r_m_tvalid <= 1'b1;
            r_m_tdata  <= w_sel_data;
            r_m_tkeep  <= w_sel_keep;
            r_m_tlast  <= w_sel_last;
            r_m_tsize  <= w_sel_size;
            r_m_tsrc   <= w_sel_src;
            r_m_tdst   <= w_sel_dst;
        end else if (m_axis_tready) begin
            r_m_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge axis_aclk or posedge axis_rst) begin
        if (axis_rst) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                r_pkt_count[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (w_accept && w_sel_last && (r_grant == c_IDX_W'(i))) begin
                    r_pkt_count[i] <= r_pkt_count[i] + CNT_W'(1);
                end
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_PORTS; g++) begin : g_cnt
            assign pkt_count[CNT_W*g +: CNT_W] = r_pkt_count[g];
        end
    endgenerate

    assign m_axis_tvalid     = r_m_tvalid;
    assign m_axis_tdata      = r_m_tdata;
    assign m_axis_tkeep      = r_m_tkeep;
    assign m_axis_tlast      = r_m_tlast;
    assign m_axis_tuser_size = r_m_tsize;
    assign m_axis_tuser_src  = r_m_tsrc;
    assign m_axis_tuser_dst  = r_m_tdst;
    assign grant_idx         = 4'(r_grant);
    assign busy              = (r_state == c_ST_PKT);

endmodule
`default_nettype wire

// File: tb/tb_axi_stream_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_stream_rr_arbiter
// Purpose  : Directed self-checking bench for axi_stream_rr_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_stream_rr_arbiter;

    localparam int NP = 2;
    localparam int CW = 4;

    typedef struct {
        logic [15:0] tag;
        logic        last;
        logic [15:0] size;
        logic [15:0] src;
        logic [15:0] dst;
    } beat_t;

    typedef struct {
        logic [15:0] tag;
        logic        last;
        logic [63:0] keep;
        logic [15:0] size;
        logic [15:0] src;
        logic [15:0] dst;
        int          cyc;
    } obs_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NP-1:0]       s_tvalid;
    logic [512*NP-1:0]   s_tdata;
    logic [64*NP-1:0]    s_tkeep;
    logic [NP-1:0]       s_tlast;
    logic [16*NP-1:0]    s_tsize;
    logic [16*NP-1:0]    s_tsrc;
    logic [16*NP-1:0]    s_tdst;
    logic [NP-1:0]       s_tready;
    logic                m_tvalid;
    logic [511:0]        m_tdata;
    logic [63:0]         m_tkeep;
    logic                m_tlast;
    logic [15:0]         m_tsize;
    logic [15:0]         m_tsrc;
    logic [15:0]         m_tdst;
    logic                m_tready;
    logic [3:0]          grant_idx;
    logic                busy;
    logic [CW*NP-1:0]    pkt_count;

    beat_t q0[$];
    beat_t q1[$];
    obs_t  obs[$];
    int    n_checks = 0;
    int    n_errors = 0;
    int    cyc      = 0;

    always #5 clk = ~clk;

    axi_stream_rr_arbiter #(.NUM_PORTS(NP), .CNT_W(CW)) dut (
        .axis_aclk         (clk),
        .axis_rst          (rst),
        .s_axis_tvalid     (s_tvalid),
        .s_axis_tdata      (s_tdata),
        .s_axis_tkeep      (s_tkeep),
        .s_axis_tlast      (s_tlast),
        .s_axis_tuser_size (s_tsize),
        .s_axis_tuser_src  (s_tsrc),
        .s_axis_tuser_dst  (s_tdst),
        .s_axis_tready     (s_tready),
        .m_axis_tvalid     (m_tvalid),
        .m_axis_tdata      (m_tdata),
        .m_axis_tkeep      (m_tkeep),
        .m_axis_tlast      (m_tlast),
        .m_axis_tuser_size (m_tsize),
        .m_axis_tuser_src  (m_tsrc),
        .m_axis_tuser_dst  (m_tdst),
        .m_axis_tready     (m_tready),
        .grant_idx         (grant_idx),
        .busy              (busy),
        .pkt_count         (pkt_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] keep_of(input logic last);
        return last ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    endfunction

    task automatic add_pkt(input int port, input int pkt, input int nb,
                           input logic [15:0] size, input logic [15:0] src, input logic [15:0] dst);
        beat_t b;
        for (int i = 0; i < nb; i++) begin
            b.tag  = {4'(port), 8'(pkt), 4'(i)};
            b.last = (i == nb - 1);
            b.size = size;
            b.src  = src;
            b.dst  = dst;
            if (port == 0) q0.push_back(b);
            else           q1.push_back(b);
        end
    endtask

    task automatic drive();
        s_tvalid = '0; s_tdata = '0; s_tkeep = '0; s_tlast = '0;
        s_tsize  = '0; s_tsrc  = '0; s_tdst  = '0;
        if (q0.size() > 0) begin
            s_tvalid[0] = 1'b1;
            s_tdata[0 +: 512] = {32{q0[0].tag}};
            s_tkeep[0 +: 64]  = keep_of(q0[0].last);
            s_tlast[0]        = q0[0].last;
            s_tsize[0 +: 16]  = q0[0].size;
            s_tsrc[0 +: 16]   = q0[0].src;
            s_tdst[0 +: 16]   = q0[0].dst;
        end
        if (q1.size() > 0) begin
            s_tvalid[1] = 1'b1;
            s_tdata[512 +: 512] = {32{q1[0].tag}};
            s_tkeep[64 +: 64]   = keep_of(q1[0].last);
            s_tlast[1]          = q1[0].last;
            s_tsize[16 +: 16]   = q1[0].size;
            s_tsrc[16 +: 16]    = q1[0].src;
            s_tdst[16 +: 16]    = q1[0].dst;
        end
    endtask

    // One clock: sample handshakes mid-cycle, then advance sources after the edge.
    task automatic step();
        logic [NP-1:0] acc;
        obs_t o;
        @(negedge clk);
        acc = s_tvalid & s_tready;
        if (m_tvalid && m_tready) begin
            o.tag = m_tdata[15:0]; o.last = m_tlast; o.keep = m_tkeep;
            o.size = m_tsize; o.src = m_tsrc; o.dst = m_tdst; o.cyc = cyc;
            obs.push_back(o);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (acc[0]) void'(q0.pop_front());
        if (acc[1]) void'(q1.pop_front());
        drive();
    endtask

    task automatic wait_obs(input int n, input int budget);
        int k = 0;
        while (obs.size() < n && k < budget) begin
            step();
            k++;
        end
        check("obs_timeout", 64'(obs.size() >= n), 64'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        q0.delete();
        q1.delete();
        m_tready = 1'b1;
        drive();
        repeat (2) step();
        rst = 1'b0;
        obs.delete();
    endtask

    initial begin
        logic [15:0] exp_rr [8];
        int          gaps   [7];
        int          t0;
        int          k;

        m_tready = 1'b1;
        drive();
        repeat (3) step();
        check("rst_mvalid", 64'(m_tvalid), 64'd0);
        check("rst_sready", 64'(s_tready), 64'd0);
        check("rst_grant",  64'(grant_idx), 64'd0);
        check("rst_busy",   64'(busy), 64'd0);
        check("rst_cnt",    64'(pkt_count), 64'd0);
        check("rst_mdata",  m_tdata[63:0], 64'd0);
        rst = 1'b0;
        obs.delete();

        // Single port 1, 3 beats
        t0 = cyc;
        add_pkt(1, 0, 3, 16'd150, 16'd1, 16'd7);
        drive();
        wait_obs(3, 20);
        for (int i = 0; i < 3 && i < obs.size(); i++) begin
            check("single_tag",  64'(obs[i].tag), 64'(16'h1000 + 16'(i)));
            check("single_cyc",  64'(obs[i].cyc), 64'(t0 + 2 + i));
            check("single_fld",  {16'(obs[i].size), obs[i].src, obs[i].dst, 16'd0},
                                 {16'd150, 16'd1, 16'd7, 16'd0});
            check("single_keep", obs[i].keep, keep_of(i == 2));
            check("single_last", 64'(obs[i].last), 64'(i == 2));
        end
        check("single_cnt1", 64'(pkt_count[CW +: CW]), 64'd1);
        check("single_cnt0", 64'(pkt_count[0 +: CW]), 64'd0);
        check("single_gidx", 64'(grant_idx), 64'd1);

        // Round-robin, two 2-beat packets per port
        obs.delete();
        add_pkt(0, 1, 2, 16'd100, 16'd0, 16'd2);
        add_pkt(0, 2, 2, 16'd100, 16'd0, 16'd2);
        add_pkt(1, 1, 2, 16'd120, 16'd1, 16'd3);
        add_pkt(1, 2, 2, 16'd120, 16'd1, 16'd3);
        drive();
        exp_rr = '{16'h0010, 16'h0011, 16'h1010, 16'h1011, 16'h0020, 16'h0021, 16'h1020, 16'h1021};
        gaps   = '{1, 2, 1, 2, 1, 2, 1};
        wait_obs(8, 40);
        for (int i = 0; i < 8 && i < obs.size(); i++) begin
            check("rr_order", 64'(obs[i].tag), 64'(exp_rr[i]));
            if (i > 0) check("rr_gap", 64'(obs[i].cyc - obs[i-1].cyc), 64'(gaps[i-1]));
        end

        // Late requester: port 1 arrives while port 0 is mid-packet
        obs.delete();
        add_pkt(0, 3, 5, 16'd300, 16'd0, 16'd4);
        drive();
        repeat (3) step();
        add_pkt(1, 3, 2, 16'd64, 16'd1, 16'd5);
        drive();
        wait_obs(7, 30);
        for (int i = 0; i < 5 && i < obs.size(); i++) begin
            check("late_p0", 64'(obs[i].tag), 64'(16'h0030 + 16'(i)));
        end
        if (obs.size() >= 7) begin
            check("late_p1_first", 64'(obs[5].tag), 64'h1030);
            check("late_p1_delay", 64'(obs[5].cyc - obs[4].cyc), 64'd2);
        end

        // Backpressure: downstream ready 1,0,0,1 during a 4-beat packet
        obs.delete();
        add_pkt(0, 4, 4, 16'd256, 16'd0, 16'd6);
        drive();
        k = 0;
        while (!m_tvalid && k < 20) begin
            step();
            k++;
        end
        check("bp_start", 64'(m_tvalid), 64'd1);
        check("bp_beat0", 64'(m_tdata[15:0]), 64'h0040);
        step();
        check("bp_beat1", 64'(m_tdata[15:0]), 64'h0041);
        m_tready = 1'b0;
        #1;
        check("bp_sready_stall", 64'(s_tready), 64'd0);
        for (int s = 0; s < 2; s++) begin
            step();
            check("bp_hold_valid", 64'(m_tvalid), 64'd1);
            check("bp_hold_data",  m_tdata[63:0], {4{16'h0041}});
            check("bp_hold_sready", 64'(s_tready), 64'd0);
            check("bp_busy", 64'(busy), 64'd1);
        end
        m_tready = 1'b1;
        wait_obs(4, 20);
        check("bp_count", 64'(obs.size()), 64'd4);
        for (int i = 0; i < 4 && i < obs.size(); i++) begin
            check("bp_order", 64'(obs[i].tag), 64'(16'h0040 + 16'(i)));
        end

        // Reset during beat 2 of 4
        obs.delete();
        add_pkt(0, 5, 4, 16'd256, 16'd0, 16'd6);
        drive();
        k = 0;
        while (!m_tvalid && k < 20) begin
            step();
            k++;
        end
        step();
        check("mrst_beat1", 64'(m_tdata[15:0]), 64'h0051);
        rst = 1'b1;
        #1;
        check("mrst_mvalid", 64'(m_tvalid), 64'd0);
        check("mrst_sready", 64'(s_tready), 64'd0);
        check("mrst_busy",   64'(busy), 64'd0);
        check("mrst_cnt",    64'(pkt_count), 64'd0);
        do_reset();
        add_pkt(1, 6, 1, 16'd64, 16'd1, 16'd1);
        add_pkt(0, 6, 1, 16'd64, 16'd0, 16'd1);
        drive();
        wait_obs(2, 20);
        if (obs.size() >= 2) begin
            check("mrst_first", 64'(obs[0].tag), 64'h0060);
            check("mrst_second", 64'(obs[1].tag), 64'h1060);
        end
        check("mrst_cnt_after", 64'(pkt_count), 64'h11);

        // Counter wrap with 4-bit counters
        do_reset();
        for (int i = 0; i < 17; i++) add_pkt(0, i, 1, 16'd64, 16'd0, 16'd0);
        drive();
        wait_obs(17, 80);
        check("wrap_cnt0", 64'(pkt_count[0 +: CW]), 64'd1);
        check("wrap_cnt1", 64'(pkt_count[CW +: CW]), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_stream_rr_arbiter.md
Name: axi_stream_rr_arbiter

Overview:
- Packet-level round-robin arbiter that merges NUM_PORTS flattened 512-bit AXI4-Stream slave ports (tuser_size/src/dst sideband) onto one master port.
- Sits between per-queue/per-plugin stream sources and a single shared downstream consumer, e.g. the box-to-MAC/QDMA path.
- Grants whole packets only; beats of different packets never interleave.
- Registered output stage plus per-port packet counters for debug.

Parameters:
- NUM_PORTS, 2, number of slave ports; legal range 1..16.
- CNT_W, 32, width of each per-port packet counter.

Ports:
- axis_aclk  input  1  clock, all logic rising-edge.
- axis_rst  input  1  asynchronous, active-high reset.
- s_axis_tvalid  input  NUM_PORTS  per-port valid.
- s_axis_tdata  input  512*NUM_PORTS  port i at bits [512*i +: 512].
- s_axis_tkeep  input  64*NUM_PORTS  byte enables, port i at [64*i +: 64].
- s_axis_tlast  input  NUM_PORTS  end of packet.
- s_axis_tuser_size  input  16*NUM_PORTS  packet length in bytes.
- s_axis_tuser_src  input  16*NUM_PORTS  source id.
- s_axis_tuser_dst  input  16*NUM_PORTS  destination id.
- s_axis_tready  output  NUM_PORTS  per-port ready.
- m_axis_tvalid  output  1  merged valid.
- m_axis_tdata  output  512  merged data.
- m_axis_tkeep  output  64  merged keep.
- m_axis_tlast  output  1  merged last.
- m_axis_tuser_size  output  16  merged size.
- m_axis_tuser_src  output  16  merged src.
- m_axis_tuser_dst  output  16  merged dst.
- m_axis_tready  input  1  downstream ready.
- grant_idx  output  4  currently or last granted port index.
- busy  output  1  high while in state PKT.
- pkt_count  output  CNT_W*NUM_PORTS  packets forwarded per port, port i at [CNT_W*i +: CNT_W].

Behaviour:
- Reset (async assert, sync release): state=IDLE; m_axis_tvalid=0; m_axis_tdata, tkeep, tlast and tuser_* = 0; s_axis_tready=0; last_grant=NUM_PORTS-1, so port 0 has first priority; grant_idx=0; busy=0; all pkt_count=0.
- State IDLE:
  - If any s_axis_tvalid is set, pick the first valid port scanning from (last_grant+1) mod NUM_PORTS upward with wrap.
  - Register the pick into grant and last_grant; go to PKT next cycle.
  - All s_axis_tready=0 in IDLE.
- State PKT:
  - s_axis_tready[grant] = ~m_axis_tvalid | m_axis_tready; every other tready=0.
  - tready is a function only of registered state and m_axis_tready; it never depends on s_axis_tvalid.
  - A beat is accepted when s_axis_tvalid[grant] & s_axis_tready[grant]; all fields are captured into the output register on that edge.
  - When the accepted beat has tlast=1: pkt_count[grant] increments (wraps at 2^CNT_W-1 -> 0) and the state returns to IDLE.
- Output register:
  - m_axis_tvalid sets on accept.
  - It clears when m_axis_tready=1 and no new accept occurs in the same cycle.
  - Fields hold while tvalid=1 and tready=0.
  - Data latency is 1 cycle from slave accept to master valid.
  - Full throughput within a packet.
- Inter-packet gap: exactly one IDLE cycle between tlast accept and the next packet's first accept; no slave beat is accepted in that cycle.
  - The last output beat may still drain during IDLE.
- Fairness: after port k is served, every other requesting port is served before k again.
- Single requester: same port re-granted each packet, with the 1-cycle gap.
- NUM_PORTS=1: degenerates to a register slice plus the 1-cycle gap.
- A valid dropping on a non-granted port before it is granted is legal; that port is simply not selected.
- A slave dropping tvalid mid-packet (protocol violation upstream): the arbiter stays in PKT with the grant held; no timeout.
- Mid-packet reset: everything returns to reset values immediately, and the partial packet is lost downstream.
- grant_idx is zero-extended to 4 bits.

Test Plan:
- Single port: NUM_PORTS=2, port 1 sends a 3-beat packet (size=150, src=1, dst=7), m_axis_tready=1 -> 3 beats on master with identical fields, 1-cycle latency, pkt_count[1]=1, pkt_count[0]=0.
- Round-robin: ports 0 and 1 each continuously send 2-beat packets -> master order 0,1,0,1, one idle cycle between packets, beats never interleaved.
- Backpressure: m_axis_tready toggling 1,0,0,1 during a 4-beat packet -> no beat lost or duplicated, fields stable while stalled, s_axis_tready low while the output is full and stalled.
- Late requester: port 0 is mid 5-beat packet when port 1 raises valid -> port 1 is granted only after port 0's tlast; port 1's first beat appears 2 cycles after port 0's last accept.
- Counter wrap: CNT_W=4, port 0 sends 17 single-beat packets -> pkt_count[0]=1.
- Reset mid-packet: assert axis_rst during beat 2 of 4 -> m_axis_tvalid=0 and s_axis_tready=0 immediately. After release, port 0 is granted first and the counters read 0.
